// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants and types for the data-RAM arbiter
package dmem_arb_pkg;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 8;
    localparam int BURST_W       = 8;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_AUX = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// rtl/dmem_arbiter_rr.sv - two-input round-robin grant with an m1 hold input
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic hold1_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic last_winner_o
);

    logic last_winner_q;
    logic last_winner_d;
    logic winner;

    always_comb begin
        winner = MST_CPU;
        if (req0_i && req1_i) begin
            // hold1_i already folds in the burst limit, so it only extends an m1 run
            winner = (hold1_i && (last_winner_q == MST_AUX)) ? MST_AUX : ~last_winner_q;
        end else if (req1_i) begin
            winner = MST_AUX;
        end
        gnt0_o        = req0_i & (winner == MST_CPU);
        gnt1_o        = req1_i & (winner == MST_AUX);
        last_winner_d = (req0_i | req1_i) ? winner : last_winner_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_winner_q <= MST_AUX;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end

    assign last_winner_o = last_winner_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one synchronous data RAM port between cpu (m0) and aux (m1)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic              m1_lock_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              ram_wEn_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_dataIn_o,
    input  logic [DATA_W-1:0] ram_dataOut_i
);

    localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

    logic [BURST_W-1:0] burst_cnt_q;
    logic [BURST_W-1:0] burst_cnt_d;
    rd_tag_t            rd_tag_q;
    rd_tag_t            rd_tag_d;
    logic               hold1;
    logic               last_winner;
    logic               win_we;

    // A nonzero count means m1 owns the current run; at the limit m0 gets through
    assign hold1 = m1_lock_i && (burst_cnt_q != '0) && (burst_cnt_q < MAX_CNT);

    rr_arbiter2 u_rr (
        .clk_i         (clock_i),
        .rst_i         (reset_i),
        .req0_i        (m0_req_i),
        .req1_i        (m1_req_i),
        .hold1_i       (hold1),
        .gnt0_o        (m0_gnt_o),
        .gnt1_o        (m1_gnt_o),
        .last_winner_o (last_winner)
    );

    always_comb begin
        win_we       = 1'b0;
        ram_addr_o   = '0;
        ram_dataIn_o = '0;
        if (m0_gnt_o) begin
            win_we       = m0_we_i;
            ram_addr_o   = m0_addr_i;
            ram_dataIn_o = m0_wdata_i;
        end else if (m1_gnt_o) begin
            win_we       = m1_we_i;
            ram_addr_o   = m1_addr_i;
            ram_dataIn_o = m1_wdata_i;
        end
        ram_wEn_o = win_we;

        burst_cnt_d = burst_cnt_q;
        if (m1_gnt_o) begin
            if ((last_winner == MST_AUX) && m1_lock_i) begin
                burst_cnt_d = (burst_cnt_q == MAX_CNT) ? MAX_CNT : burst_cnt_q + 1'b1;
            end else begin
                burst_cnt_d = BURST_W'(1);
            end
        end else if (m0_gnt_o) begin
            burst_cnt_d = '0;
        end

        rd_tag_d.valid = (m0_gnt_o | m1_gnt_o) & ~win_we;
        rd_tag_d.id    = m1_gnt_o ? MST_AUX : MST_CPU;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            burst_cnt_q <= '0;
            rd_tag_q    <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            rd_tag_q    <= rd_tag_d;
        end
    end

    assign m0_rvalid_o = rd_tag_q.valid && (rd_tag_q.id == MST_CPU);
    assign m1_rvalid_o = rd_tag_q.valid && (rd_tag_q.id == MST_AUX);
    assign m0_rdata_o  = m0_rvalid_o ? ram_dataOut_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? ram_dataOut_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [11:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [11:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        ram_wEn;
    logic [11:0] ram_addr;
    logic [31:0] ram_dataIn, ram_dataOut;
    logic [31:0] mem [0:4095];

    int checks;
    int failures;

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(8)) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .m0_req_i      (m0_req),
        .m0_we_i       (m0_we),
        .m0_addr_i     (m0_addr),
        .m0_wdata_i    (m0_wdata),
        .m0_gnt_o      (m0_gnt),
        .m0_rvalid_o   (m0_rvalid),
        .m0_rdata_o    (m0_rdata),
        .m1_req_i      (m1_req),
        .m1_we_i       (m1_we),
        .m1_addr_i     (m1_addr),
        .m1_wdata_i    (m1_wdata),
        .m1_lock_i     (m1_lock),
        .m1_gnt_o      (m1_gnt),
        .m1_rvalid_o   (m1_rvalid),
        .m1_rdata_o    (m1_rdata),
        .ram_wEn_o     (ram_wEn),
        .ram_addr_o    (ram_addr),
        .ram_dataIn_o  (ram_dataIn),
        .ram_dataOut_i (ram_dataOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    typedef struct packed {
        logic        m0_req;
        logic        m0_we;
        logic [11:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic        m1_we;
        logic [11:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        lock;
        logic        g0;
        logic        g1;
        logic        wen;
        logic [11:0] raddr;
        logic [31:0] din;
        logic        rv0;
        logic [31:0] rd0;
        logic        rv1;
        logic [31:0] rd1;
    } vec_t;

    vec_t tv [0:18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        m0_req = v.m0_req; m0_we = v.m0_we; m0_addr = v.m0_addr; m0_wdata = v.m0_wdata;
        m1_req = v.m1_req; m1_we = v.m1_we; m1_addr = v.m1_addr; m1_wdata = v.m1_wdata;
        m1_lock = v.lock;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h010] = 32'hDEADBEEF;
        mem[12'h011] = 32'h11111111;
        mem[12'h012] = 32'h22222222;
        mem[12'h013] = 32'h33333333;
        mem[12'h014] = 32'h44444444;
        mem[12'h015] = 32'h55555555;
        mem[12'h016] = 32'h66666666;

        //             m0 req we addr   wdata          m1 req we addr   wdata          lk  g0 g1 wen raddr  din            rv0 rd0            rv1 rd1
        tv[0]  = '{1'b1,1'b0,12'h010,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b1,1'b0,1'b0,12'h010,32'h0,        1'b0,32'h0,        1'b0,32'h0};
        tv[1]  = '{1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,12'h000,32'h0,        1'b1,32'hDEADBEEF, 1'b0,32'h0};
        tv[2]  = '{1'b0,1'b0,12'h000,32'h0,        1'b1,1'b0,12'h012,32'h0,        1'b0,1'b0,1'b1,1'b0,12'h012,32'h0,        1'b0,32'h0,        1'b0,32'h0};
        tv[3]  = '{1'b1,1'b0,12'h011,32'h0,        1'b1,1'b0,12'h013,32'h0,        1'b0,1'b1,1'b0,1'b0,12'h011,32'h0,        1'b0,32'h0,        1'b1,32'h22222222};
        tv[4]  = '{1'b1,1'b0,12'h014,32'h0,        1'b1,1'b0,12'h013,32'h0,        1'b0,1'b0,1'b1,1'b0,12'h013,32'h0,        1'b1,32'h11111111, 1'b0,32'h0};
        tv[5]  = '{1'b1,1'b0,12'h014,32'h0,        1'b1,1'b0,12'h015,32'h0,        1'b0,1'b1,1'b0,1'b0,12'h014,32'h0,        1'b0,32'h0,        1'b1,32'h33333333};
        tv[6]  = '{1'b1,1'b0,12'h016,32'h0,        1'b1,1'b0,12'h015,32'h0,        1'b0,1'b0,1'b1,1'b0,12'h015,32'h0,        1'b1,32'h44444444, 1'b0,32'h0};
        tv[7]  = '{1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,12'h000,32'h0,        1'b0,32'h0,        1'b1,32'h55555555};
        tv[8]  = '{1'b0,1'b0,12'h000,32'h0,        1'b1,1'b1,12'h020,32'h0000CAFE, 1'b0,1'b0,1'b1,1'b1,12'h020,32'h0000CAFE, 1'b0,32'h0,        1'b0,32'h0};
        tv[9]  = '{1'b1,1'b0,12'h020,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b1,1'b0,1'b0,12'h020,32'h0,        1'b0,32'h0,        1'b0,32'h0};
        tv[10] = '{1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,12'h000,32'h0,        1'b1,32'h0000CAFE, 1'b0,32'h0};
        tv[11] = '{1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,12'h000,32'h0,        1'b0,32'h0,        1'b0,32'h0};
        tv[12] = '{1'b1,1'b0,12'h010,32'h0,        1'b1,1'b0,12'h011,32'h0,        1'b0,1'b0,1'b1,1'b0,12'h011,32'h0,        1'b0,32'h0,        1'b0,32'h0};
        tv[13] = '{1'b1,1'b0,12'h010,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b1,1'b0,1'b0,12'h010,32'h0,        1'b0,32'h0,        1'b1,32'h11111111};
        tv[14] = '{1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,12'h000,32'h0,        1'b1,32'hDEADBEEF, 1'b0,32'h0};
        tv[15] = '{1'b1,1'b1,12'h7FF,32'h12345678, 1'b0,1'b0,12'h000,32'h0,        1'b0,1'b1,1'b0,1'b1,12'h7FF,32'h12345678, 1'b0,32'h0,        1'b0,32'h0};
        tv[16] = '{1'b0,1'b0,12'h000,32'h0,        1'b1,1'b0,12'h7FF,32'h0,        1'b0,1'b0,1'b1,1'b0,12'h7FF,32'h0,        1'b0,32'h0,        1'b0,32'h0};
        tv[17] = '{1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,12'h000,32'h0,        1'b0,32'h0,        1'b1,32'h12345678};
        tv[18] = '{1'b1,1'b0,12'h010,32'h0,        1'b0,1'b0,12'h000,32'h0,        1'b0,1'b1,1'b0,1'b0,12'h010,32'h0,        1'b0,32'h0,        1'b0,32'h0};

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("reset_m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("reset_ram_wEn", 32'(ram_wEn), 32'h0);
        chk("reset_ram_addr", 32'(ram_addr), 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 19; i++) begin
            drive(tv[i]);
            @(negedge clock);
            chk($sformatf("v%0d_m0_gnt", i), 32'(m0_gnt), 32'(tv[i].g0));
            chk($sformatf("v%0d_m1_gnt", i), 32'(m1_gnt), 32'(tv[i].g1));
            chk($sformatf("v%0d_ram_wEn", i), 32'(ram_wEn), 32'(tv[i].wen));
            chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(tv[i].raddr));
            chk($sformatf("v%0d_ram_dataIn", i), ram_dataIn, tv[i].din);
            chk($sformatf("v%0d_m0_rvalid", i), 32'(m0_rvalid), 32'(tv[i].rv0));
            chk($sformatf("v%0d_m0_rdata", i), m0_rdata, tv[i].rd0);
            chk($sformatf("v%0d_m1_rvalid", i), 32'(m1_rvalid), 32'(tv[i].rv1));
            chk($sformatf("v%0d_m1_rdata", i), m1_rdata, tv[i].rd1);
            @(posedge clock);
            #1;
        end

        // Locked m1 burst from last_winner = m0: eight m1 grants, forced m0, then m1 again
        for (int c = 0; c < 12; c++) begin
            m0_req = 1; m0_we = 0; m0_addr = 12'h030; m0_wdata = '0;
            m1_req = 1; m1_we = 0; m1_addr = 12'h031; m1_wdata = '0; m1_lock = 1;
            @(negedge clock);
            chk($sformatf("lock_c%0d_m1_gnt", c), 32'(m1_gnt), (c == 8) ? 32'h0 : 32'h1);
            chk($sformatf("lock_c%0d_m0_gnt", c), 32'(m0_gnt), (c == 8) ? 32'h1 : 32'h0);
            @(posedge clock);
            #1;
        end

        // Saturated count with m0 idle: m1 keeps the port, then m0 is let in immediately
        m0_req = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk($sformatf("sat_c%0d_m1_gnt", c), 32'(m1_gnt), 32'h1);
            @(posedge clock);
            #1;
        end
        m0_req = 1;
        @(negedge clock);
        chk("sat_release_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("sat_release_m1_gnt", 32'(m1_gnt), 32'h0);
        @(posedge clock);
        #1;

        // Reset asserted in the cycle after an m1 read grant drops the pending rvalid
        idle();
        m1_req = 1; m1_addr = 12'h012;
        @(negedge clock);
        chk("rst_pre_m1_gnt", 32'(m1_gnt), 32'h1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle();
        #2;
        chk("rst_mid_m1_rvalid", 32'(m1_rvalid), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_after_m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("rst_after_m0_rvalid", 32'(m0_rvalid), 32'h0);
        @(posedge clock);
        #1;
        m0_req = 1; m0_addr = 12'h010;
        m1_req = 1; m1_addr = 12'h011;
        @(negedge clock);
        chk("rst_first_contention_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("rst_first_contention_m1_gnt", 32'(m1_gnt), 32'h0);
        @(posedge clock);
        #1;
        idle();
        @(negedge clock);
        chk("rst_read_m0_rvalid", 32'(m0_rvalid), 32'h1);
        chk("rst_read_m0_rdata", m0_rdata, 32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
